fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-outstanding-request fetch with redirect
// handling, combinational predecode for the branch predictor, and a circular fetch queue to decode.
module fetch_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] target_pc,
  input  logic        predict_result,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] imm,
  output logic        branch,
  output logic        predict,
  output logic        excp,
  output logic        sret,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic        pred_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_predict
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic {FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        predict;
  } entry_t;

  state_t        state_reg;
  logic [31:0]   pc_reg;
  logic [31:0]   redirect_reg;
  logic          pending_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  entry_t        queue_mem [QUEUE_DEPTH];

  logic   commit;
  logic   pop;
  entry_t head;

  // A request already on the bus stays up, with the same address, until answered.
  assign imem_req   = !rst && (pending_reg || (state_reg == FETCH && count_reg < DEPTH_C));
  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign commit     = (state_reg == FETCH) && imem_req && imem_ready && !flush;
  assign pred_stall = !commit;
  assign out_valid  = (count_reg != '0);
  assign pop        = out_valid && out_ready;

  assign head        = queue_mem[rd_ptr_reg];
  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign out_predict = head.predict;

  always_comb begin
    branch  = 1'b0;
    predict = 1'b0;
    imm     = 32'h0;
    excp    = (imem_rdata == 32'h00000073) || (imem_rdata == 32'h10200073);
    sret    = (imem_rdata == 32'h10200073);
    rs1     = imem_rdata[19:15];
    rd      = imem_rdata[11:7];
    case (imem_rdata[6:0])
      7'b1100011: begin
        branch  = 1'b1;
        predict = 1'b1;
        imm     = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                   imem_rdata[30:25], imem_rdata[11:8], 1'b0};
      end
      7'b1101111: begin
        branch = 1'b1;
        imm    = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};
      end
      7'b1100111: begin
        branch = 1'b1;
        imm    = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      queue_mem[wr_ptr_reg] <= '{inst: imem_rdata, pc: pc_reg, predict: predict_result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      redirect_reg <= 32'h0;
      pending_reg  <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (imem_req) begin
        pending_reg <= !imem_ready;
      end

      case (state_reg)
        FETCH: begin
          if (flush) begin
            if (imem_req && !imem_ready) begin
              redirect_reg <= target_pc;
              state_reg    <= DISCARD;
            end else begin
              pc_reg <= target_pc;
            end
          end else if (commit) begin
            pc_reg <= target_pc;
          end
        end
        DISCARD: begin
          // The stale response is simply not pushed; a fresh flush wins over the saved redirect.
          if (flush) begin
            redirect_reg <= target_pc;
          end
          if (imem_ready) begin
            pc_reg    <= flush ? target_pc : redirect_reg;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase

      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (commit && !pop)      count_reg <= count_reg + 1'b1;
        else if (pop && !commit) count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, backpressure, flush/discard,
// predecode and asynchronous reset, with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] target_pc;
  logic        predict_result;
  logic        flush;
  logic [31:0] pc, imm;
  logic        branch, predict, excp, sret;
  logic [4:0]  rs1, rd;
  logic        pred_stall;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst, out_pc;
  logic        out_predict;

  int compared = 0;
  int mismatched = 0;

  fetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .target_pc(target_pc), .predict_result(predict_result), .flush(flush),
    .pc(pc), .imm(imm), .branch(branch), .predict(predict), .excp(excp), .sret(sret),
    .rs1(rs1), .rd(rd), .pred_stall(pred_stall),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_predict(out_predict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h13; target_pc = 32'h0;
    predict_result = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Reset state
    next_cycle(); #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_stall", {31'h0, pred_stall}, 32'h1);

    // Zero-wait streaming, out_pc one cycle behind
    next_cycle();
    rst = 1'b0; out_ready = 1'b1; imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 32'(4 * k);
      target_pc = a + 32'd4;
      #1;
      chk($sformatf("stream_addr%0d", k), imem_addr, a);
      chk($sformatf("stream_req%0d", k), {31'h0, imem_req}, 32'h1);
      chk($sformatf("stream_stall%0d", k), {31'h0, pred_stall}, 32'h0);
      chk($sformatf("stream_valid%0d", k), {31'h0, out_valid}, (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) chk($sformatf("stream_outpc%0d", k), out_pc, a - 32'd4);
      next_cycle();
    end

    // Flush coincident with imem_ready: response dropped
    out_ready = 1'b0; flush = 1'b1; target_pc = 32'h40; #1;
    chk("flushrdy_stall", {31'h0, pred_stall}, 32'h1);
    next_cycle();
    flush = 1'b0; #1;
    chk("flushrdy_valid", {31'h0, out_valid}, 32'h0);
    chk("flushrdy_addr", imem_addr, 32'h40);

    // Backpressure: fill four entries
    for (int k = 0; k < 4; k++) begin
      a = 32'h40 + 32'(4 * k);
      imem_rdata = 32'h00000013 | (32'(k) << 20);
      target_pc = a + 32'd4;
      #1;
      chk($sformatf("fill_addr%0d", k), imem_addr, a);
      next_cycle();
    end
    #1;
    chk("full_req", {31'h0, imem_req}, 32'h0);
    chk("full_stall", {31'h0, pred_stall}, 32'h1);
    chk("full_head_pc", out_pc, 32'h40);
    chk("full_head_inst", out_inst, 32'h00000013);
    next_cycle();
    #1;
    chk("hold_pc", pc, 32'h50);
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0; imem_rdata = 32'h00400013; target_pc = 32'h54; #1;
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h50);
    chk("order_pc", out_pc, 32'h44);
    chk("order_inst", out_inst, 32'h00100013);
    next_cycle();

    // Drain while a request at 0x54 waits on slow memory
    out_ready = 1'b1; imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain_pc%0d", k), out_pc, 32'h44 + 32'(4 * k));
      next_cycle();
    end
    #1;
    chk("drained_valid", {31'h0, out_valid}, 32'h0);
    chk("wait_addr", imem_addr, 32'h54);

    // Flush on a waiting request: DISCARD, address held, stale response dropped
    flush = 1'b1; target_pc = 32'h100;
    next_cycle();
    flush = 1'b0; #1;
    chk("disc_req", {31'h0, imem_req}, 32'h1);
    chk("disc_addr_held", imem_addr, 32'h54);
    next_cycle();
    imem_ready = 1'b1; imem_rdata = 32'h00000013; #1;
    chk("disc_drop_stall", {31'h0, pred_stall}, 32'h1);
    next_cycle();
    imem_ready = 1'b0; #1;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", {31'h0, out_valid}, 32'h0);

    // Second flush inside DISCARD overwrites the redirect
    flush = 1'b1; target_pc = 32'h200;
    next_cycle();
    target_pc = 32'h20;
    next_cycle();
    flush = 1'b0; imem_ready = 1'b1;
    next_cycle();

    // Predecode
    out_ready = 1'b0; predict_result = 1'b1;
    imem_rdata = 32'h00C000EF; target_pc = 32'h24; #1;
    chk("jal_pc", pc, 32'h20);
    chk("jal_branch", {31'h0, branch}, 32'h1);
    chk("jal_predict", {31'h0, predict}, 32'h0);
    chk("jal_rd", {27'h0, rd}, 32'h1);
    chk("jal_imm", imm, 32'd12);
    chk("jal_stall", {31'h0, pred_stall}, 32'h0);
    next_cycle();
    imem_rdata = 32'h10200073; target_pc = 32'h28; #1;
    chk("sret_excp", {31'h0, excp}, 32'h1);
    chk("sret_sret", {31'h0, sret}, 32'h1);
    chk("sret_branch", {31'h0, branch}, 32'h0);
    next_cycle();
    imem_rdata = 32'hFE000EE3; target_pc = 32'h2C; #1;
    chk("beq_branch", {31'h0, branch}, 32'h1);
    chk("beq_predict", {31'h0, predict}, 32'h1);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_excp", {31'h0, excp}, 32'h0);
    next_cycle();
    imem_ready = 1'b0; #1;
    chk("q_head_inst", out_inst, 32'h00C000EF);
    chk("q_head_pred", {31'h0, out_predict}, 32'h1);
    chk("q3_valid", {31'h0, out_valid}, 32'h1);

    // Asynchronous reset with three entries queued and a request pending
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_stall", {31'h0, pred_stall}, 32'h1);
    next_cycle();
    rst = 1'b0; #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req_after", {31'h0, imem_req}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
